red_pitaya_pwm_demod: RTL and testbench

Receive-side counterpart of the PWM DAC path. The block takes a dithered PWM bit stream, such as the RC-filter drive signal, either looped back or from another board, together with its frame-sync pulse. It recovers the per-frame duty count and the 16-frame dithered sum, so firmware can self-test the PWM outputs and decode remote PWM links. It sits in the analog-mixed-signal housekeeping area next to the PWM generators.

---
 rtl/red_pitaya_pwm_pkg.sv | 16 +
 rtl/red_pitaya_pwm_sync2ff.sv | 25 ++
 rtl/red_pitaya_pwm_demod.sv | 168 ++++++++++++++++
 tb/tb_red_pitaya_pwm_demod.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_pwm_pkg.sv
// Shared definitions for the PWM demodulator: default frame geometry,
// the lock state encoding and the bit positions inside err_o.
package red_pitaya_pwm_pkg;

  localparam logic [7:0] FULL_DEF   = 8'd255;
  localparam int         NFRAME_DEF = 16;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int ERR_SYNC = 0;
  localparam int ERR_EDGE = 1;

endpackage

// File: rtl/red_pitaya_pwm_sync2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// Only compiled when PWM_DEMOD_SYNC_EN is defined.
`ifdef PWM_DEMOD_SYNC_EN
module red_pitaya_pwm_sync2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the input through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/red_pitaya_pwm_demod.sv
// PWM demodulator: recovers per-frame high counts and the metacycle sum
// from a dithered PWM stream plus its frame-sync pulse.
// Optional: define PWM_DEMOD_SYNC_EN to pass pwm_i/sync_i through 2-FF
// synchronizers (adds two cycles to every latency).
module red_pitaya_pwm_demod
  import red_pitaya_pwm_pkg::*;
#(
  parameter logic [7:0] FULL   = FULL_DEF,
  parameter int         NFRAME = NFRAME_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_i,
  input  logic        sync_i,
  input  logic        clr_i,
  output logic [8:0]  frame_o,
  output logic        frame_valid_o,
  output logic [12:0] sum_o,
  output logic        sum_valid_o,
  output logic        lock_o,
  output logic [1:0]  err_o
);

  localparam int             FW        = (NFRAME > 1) ? $clog2(NFRAME) : 1;
  localparam logic [FW-1:0]  FIDX_LAST = FW'(NFRAME - 1);
  localparam logic [7:0]     FCNT_PEN  = FULL - 8'd1;

  logic pwm_bit;
  logic sync_bit;

`ifdef PWM_DEMOD_SYNC_EN
  red_pitaya_pwm_sync2ff u_sync_pwm  (.clk(clk), .rst(rst), .d(pwm_i),  .q(pwm_bit));
  red_pitaya_pwm_sync2ff u_sync_sync (.clk(clk), .rst(rst), .d(sync_i), .q(sync_bit));
`else
  assign pwm_bit  = pwm_i;
  assign sync_bit = sync_i;
`endif

  state_t        state, state_next;
  logic          pend, pend_next;
  logic [7:0]    fcnt, fcnt_next;
  logic [FW-1:0] fidx, fidx_next;
  logic [8:0]    hcnt, hcnt_next;
  logic [12:0]   acc, acc_next;
  logic          prev, prev_next;
  logic          rise_seen, rise_seen_next;
  logic [8:0]    frame_next;
  logic          frame_valid_next;
  logic [12:0]   sum_next;
  logic          sum_valid_next;
  logic [1:0]    err_next;
  logic [8:0]    frame_cnt;
  logic          rise;
  logic          aligned;

  assign frame_cnt = hcnt + {8'd0, pwm_bit};
  assign rise      = pwm_bit & ~prev;
  assign aligned   = !pend && (fcnt == FCNT_PEN) && (fidx == FIDX_LAST);
  assign lock_o    = (state == RUN);

  // Next-state and datapath decisions: (re)alignment on sync, one dead
  // cycle after alignment, then frame/metacycle counting with strobes.
  always_comb begin
    state_next       = state;
    pend_next        = pend;
    fcnt_next        = fcnt;
    fidx_next        = fidx;
    hcnt_next        = hcnt;
    acc_next         = acc;
    prev_next        = pwm_bit;
    rise_seen_next   = rise_seen;
    frame_next       = frame_o;
    frame_valid_next = 1'b0;
    sum_next         = sum_o;
    sum_valid_next   = 1'b0;
    err_next         = clr_i ? 2'b00 : err_o;

    case (state)
      HUNT: begin
        if (sync_bit) begin
          state_next     = RUN;
          pend_next      = 1'b1;
          fcnt_next      = 8'd0;
          fidx_next      = '0;
          hcnt_next      = 9'd0;
          acc_next       = 13'd0;
          rise_seen_next = 1'b0;
        end
      end
      RUN: begin
        if (sync_bit && !aligned) begin
          err_next[ERR_SYNC] = 1'b1;
          pend_next          = 1'b1;
          fcnt_next          = 8'd0;
          fidx_next          = '0;
          hcnt_next          = 9'd0;
          acc_next           = 13'd0;
          rise_seen_next     = 1'b0;
        end else if (pend) begin
          pend_next = 1'b0;
        end else begin
          if (rise && rise_seen) begin
            err_next[ERR_EDGE] = 1'b1;
          end
          if (fcnt == FULL) begin
            frame_next       = frame_cnt;
            frame_valid_next = 1'b1;
            hcnt_next        = 9'd0;
            fcnt_next        = 8'd0;
            rise_seen_next   = 1'b0;
            if (fidx == FIDX_LAST) begin
              sum_next       = acc + 13'(frame_cnt);
              sum_valid_next = 1'b1;
              acc_next       = 13'd0;
              fidx_next      = '0;
            end else begin
              acc_next  = acc + 13'(frame_cnt);
              fidx_next = fidx + FW'(1);
            end
          end else begin
            hcnt_next      = frame_cnt;
            fcnt_next      = fcnt + 8'd1;
            rise_seen_next = rise_seen | rise;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  // Counters, accumulator, registered outputs and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend          <= 1'b0;
      fcnt          <= 8'd0;
      fidx          <= '0;
      hcnt          <= 9'd0;
      acc           <= 13'd0;
      prev          <= 1'b0;
      rise_seen     <= 1'b0;
      frame_o       <= 9'd0;
      frame_valid_o <= 1'b0;
      sum_o         <= 13'd0;
      sum_valid_o   <= 1'b0;
      err_o         <= 2'b00;
    end else begin
      pend          <= pend_next;
      fcnt          <= fcnt_next;
      fidx          <= fidx_next;
      hcnt          <= hcnt_next;
      acc           <= acc_next;
      prev          <= prev_next;
      rise_seen     <= rise_seen_next;
      frame_o       <= frame_next;
      frame_valid_o <= frame_valid_next;
      sum_o         <= sum_next;
      sum_valid_o   <= sum_valid_next;
      err_o         <= err_next;
    end
  end

endmodule

// File: tb/tb_red_pitaya_pwm_demod.sv
// Testbench for red_pitaya_pwm_demod: behavioural frame/metacycle model
// plus scenario tasks with randomized and directed PWM streams.
module tb_red_pitaya_pwm_demod;

  localparam int FRAME_LEN = 256;
  localparam int NF        = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_i = 1'b0;
  logic        sync_i = 1'b0;
  logic        clr_i = 1'b0;
  logic [8:0]  frame_o;
  logic        frame_valid_o;
  logic [12:0] sum_o;
  logic        sum_valid_o;
  logic        lock_o;
  logic [1:0]  err_o;

  int checks = 0;
  int failures = 0;

  // Behavioural model: sample index since frame-0 origin, frame bit sums,
  // list of frame counts inside the current metacycle.
  int       k = 0;
  bit       locked = 1'b0;
  int       origin = 0;
  int       pos = 0;
  int       hsum = 0;
  int       rises = 0;
  int       fm = 0;
  int       msum = 0;
  bit       last = 1'b0;
  bit       exp_fv = 1'b0;
  bit       exp_sv = 1'b0;
  int       exp_frame = 0;
  int       exp_sum = 0;
  logic [1:0] exp_err = 2'b00;
  logic [26:0] obs_v;
  logic [26:0] exp_v;

  always #5 clk = ~clk;

  red_pitaya_pwm_demod dut (
    .clk(clk), .rst(rst), .pwm_i(pwm_i), .sync_i(sync_i), .clr_i(clr_i),
    .frame_o(frame_o), .frame_valid_o(frame_valid_o), .sum_o(sum_o),
    .sum_valid_o(sum_valid_o), .lock_o(lock_o), .err_o(err_o)
  );

  // Drive one cycle of inputs, advance the model over the clock edge and
  // capture observed/expected output vectors 1 ns after the edge.
  task automatic cycle(input bit p, input bit s, input bit c);
    logic [1:0] newerr;
    bit aligned;
    pwm_i = p; sync_i = s; clr_i = c;
    @(posedge clk);
    exp_fv = 1'b0; exp_sv = 1'b0; newerr = 2'b00;
    if (rst) begin
      locked = 1'b0; exp_frame = 0; exp_sum = 0; exp_err = 2'b00;
    end else begin
      aligned = locked && (k >= origin) && (pos == FRAME_LEN - 2) && (fm == NF - 1);
      if (s && !aligned) begin
        if (locked) newerr[0] = 1'b1;
        locked = 1'b1; origin = k + 2; pos = 0; hsum = 0; rises = 0; fm = 0; msum = 0;
      end else if (locked && k >= origin) begin
        if (p && !last) begin
          rises++;
          if (rises > 1) newerr[1] = 1'b1;
        end
        hsum += int'(p);
        pos++;
        if (pos == FRAME_LEN) begin
          exp_fv = 1'b1; exp_frame = hsum; msum += hsum; fm++;
          pos = 0; hsum = 0; rises = 0;
          if (fm == NF) begin
            exp_sv = 1'b1; exp_sum = msum; msum = 0; fm = 0;
          end
        end
      end
      last = p;
      exp_err = (c ? 2'b00 : exp_err) | newerr;
    end
    k++;
    #1;
    obs_v = {frame_valid_o, sum_valid_o, lock_o, err_o, frame_o, sum_o};
    exp_v = {exp_fv, exp_sv, locked, exp_err, 9'(exp_frame), 13'(exp_sum)};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_v !== 27'd0) begin
      failures++;
      $display("[TB] FAIL reset_state got=%h want=%h", obs_v, 27'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL hunt_idle k=%0d got=%h want=%h", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_const_high();
    int last_f = -1;
    do_reset();
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (lock_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lock_rise got=%b want=1", lock_o);
    end
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4096 + 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL const_cycle k=%0d got=%h want=%h", k, obs_v, exp_v);
      end
      if (frame_valid_o) begin
        checks++;
        if (frame_o !== 9'd256 || (last_f >= 0 && i - last_f != 256)) begin
          failures++;
          $display("[TB] FAIL const_frame got=%0d gap=%0d want=256 gap=256", frame_o, i - last_f);
        end
        last_f = i;
      end
      if (sum_valid_o) begin
        checks++;
        if (sum_o !== 13'd4096) begin
          failures++;
          $display("[TB] FAIL const_sum got=%0d want=4096", sum_o);
        end
      end
    end
    checks++;
    if (err_o !== 2'b00) begin
      failures++;
      $display("[TB] FAIL const_err got=%b want=00", err_o);
    end
  endtask

  task automatic test_half_duty();
    int last_s = -1;
    int nsum = 0;
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8192 + 20; i++) begin
      cycle(1'((i % 256) < 128), 1'((i % 4096) == 4094), 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL half_cycle k=%0d got=%h want=%h", k, obs_v, exp_v);
      end
      if (sum_valid_o) begin
        nsum++;
        checks++;
        if (sum_o !== 13'd2048 || frame_o !== 9'd128 || (last_s >= 0 && i - last_s != 4096)) begin
          failures++;
          $display("[TB] FAIL half_sum got=%0d frame=%0d gap=%0d want=2048 128 4096", sum_o, frame_o, i - last_s);
        end
        last_s = i;
      end
    end
    checks++;
    if (nsum != 2 || err_o !== 2'b00) begin
      failures++;
      $display("[TB] FAIL half_count got=%0d err=%b want=2 err=00", nsum, err_o);
    end
  endtask

  task automatic test_alternate();
    int nfr = 0;
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4096 + 10; i++) begin
      cycle(1'((i % 256) < (((i / 256) % 2) ? 101 : 100)), 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL alt_cycle k=%0d got=%h want=%h", k, obs_v, exp_v);
      end
      if (frame_valid_o) begin
        checks++;
        if (frame_o !== ((nfr % 2) ? 9'd101 : 9'd100)) begin
          failures++;
          $display("[TB] FAIL alt_frame n=%0d got=%0d want=%0d", nfr, frame_o, (nfr % 2) ? 101 : 100);
        end
        nfr++;
      end
      if (sum_valid_o) begin
        checks++;
        if (sum_o !== 13'd1608) begin
          failures++;
          $display("[TB] FAIL alt_sum got=%0d want=1608", sum_o);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    int first_f = -1;
    int first_s = -1;
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5 * 256 + 37; i++) begin
      cycle(1'((i % 256) < 60), 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL mis_pre k=%0d got=%h want=%h", k, obs_v, exp_v);
      end
    end
    cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (err_o !== 2'b01 || frame_valid_o !== 1'b0 || sum_valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mis_err got=%b fv=%b sv=%b want=01 0 0", err_o, frame_valid_o, sum_valid_o);
    end
    for (int j = 1; j <= 4200; j++) begin
      cycle((j >= 2) ? 1'(((j - 2) % 256) < 60) : 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL mis_post k=%0d got=%h want=%h", k, obs_v, exp_v);
      end
      if (frame_valid_o && first_f < 0) first_f = j;
      if (sum_valid_o && first_s < 0) first_s = j;
    end
    checks++;
    if (first_f != 257 || first_s != 4097) begin
      failures++;
      $display("[TB] FAIL mis_latency got frame=%0d sum=%0d want frame=257 sum=4097", first_f, first_s);
    end
  endtask

  task automatic test_edge_err();
    bit p;
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= 400; i++) begin
      p = (i >= 10 && i <= 12) || (i >= 50 && i <= 52) ||
          (i >= 266 && i <= 268) || (i >= 306 && i <= 308);
      cycle(p, 1'b0, 1'((i == 306) || (i == 400)));
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL edge_cycle k=%0d got=%h want=%h", k, obs_v, exp_v);
      end
      if (i == 30 || i == 50 || i == 306 || i == 400) begin
        checks++;
        if (err_o !== ((i == 50 || i == 306) ? 2'b10 : 2'b00)) begin
          failures++;
          $display("[TB] FAIL edge_flag i=%0d got=%b want=%b", i, err_o, (i == 50 || i == 306) ? 2'b10 : 2'b00);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    for (int i = 0; i < 8400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'(i == 3000 + int'($urandom_range(0, 300)) % 2),
            1'($urandom_range(0, 499) == 0));
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL rand_cycle k=%0d got=%h want=%h", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL rmid_pre k=%0d got=%h want=%h", k, obs_v, exp_v);
      end
    end
    rst = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    checks++;
    if (obs_v !== 27'd0) begin
      failures++;
      $display("[TB] FAIL rmid_zero got=%h want=%h", obs_v, 27'd0);
    end
    for (int i = 0; i < 50; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checks++;
      if (lock_o !== 1'b0 || obs_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL rmid_hunt k=%0d got=%h want=%h", k, obs_v, exp_v);
      end
    end
    cycle(1'b0, 1'b1, 1'b0);
    checks++;
    if (lock_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rmid_relock got=%b want=1", lock_o);
    end
  endtask

  initial begin
    test_reset();
    test_const_high();
    test_half_duty();
    test_alternate();
    test_misaligned();
    test_edge_err();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
